// File: rtl/addr8s_pkg.sv
// Shared types and widths for the redundant adder scheduler.
package addr8s_pkg;

  localparam int OP_W  = 8;
  localparam int RES_W = 9;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RUN1 = 3'd1,
    RUN2 = 3'd2,
    RUN3 = 3'd3,
    DONE = 3'd4
  } state_t;

endpackage

// File: rtl/addr8s_redundant_sched_rr_arb2.sv
// Two-requester round-robin arbiter. Grants only while enabled; after each
// grant the priority moves to the requester that was not served.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic prio_reg;  // 0: requester 0 preferred, 1: requester 1 preferred

  // Grant selection from current priority
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (prio_reg) begin
        if (req[1])      gnt = 2'b10;
        else if (req[0]) gnt = 2'b01;
      end else begin
        if (req[0])      gnt = 2'b01;
        else if (req[1]) gnt = 2'b10;
      end
    end
  end

  // Priority toggles to the other requester after every grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_reg <= 1'b0;
    end else if (|gnt) begin
      prio_reg <= gnt[0];
    end
  end

endmodule

// File: rtl/addr8s_redundant_sched.sv
// Schedules two requesters onto one shared external adder. Each operation is
// evaluated twice; on disagreement a third evaluation votes the result.
module addr8s_redundant_sched
  import addr8s_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic             req1_valid,
  input  logic [OP_W-1:0]  req0_a,
  input  logic [OP_W-1:0]  req0_b,
  input  logic [OP_W-1:0]  req1_a,
  input  logic [OP_W-1:0]  req1_b,
  output logic             req0_ready,
  output logic             req1_ready,
  output logic [OP_W-1:0]  add_a,
  output logic [OP_W-1:0]  add_b,
  input  logic [RES_W-1:0] add_o,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [RES_W-1:0] rsp_sum,
  output logic             rsp_corrected,
  output logic             rsp_err,
  output logic [CNT_W-1:0] corr_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  state_t           state_reg, state_next;
  logic [1:0]       gnt;
  logic             accept;
  logic             done_hs;
  logic [OP_W-1:0]  a_reg, b_reg;
  logic             id_reg;
  logic [RES_W-1:0] r1_reg, r2_reg, sum_reg;
  logic             corr_reg, err_reg;
  logic [1:0]       evt;

  // Arbitration is only open in IDLE and never while reset is asserted
  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .en  ((state_reg == IDLE) && !rst),
    .req ({req1_valid, req0_valid}),
    .gnt (gnt)
  );

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];
  assign accept     = |gnt;
  assign done_hs    = rsp_valid && rsp_ready;

  assign rsp_id        = id_reg;
  assign rsp_sum       = sum_reg;
  assign rsp_corrected = corr_reg;
  assign rsp_err       = err_reg;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state: early exit from RUN2 when the first two results agree
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = RUN1;
      RUN1:    state_next = RUN2;
      RUN2:    state_next = (add_o == r1_reg) ? DONE : RUN3;
      RUN3:    state_next = DONE;
      DONE:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs: adder operands only during evaluation, response valid in DONE
  always_comb begin
    rsp_valid = 1'b0;
    add_a     = '0;
    add_b     = '0;
    case (state_reg)
      RUN1, RUN2, RUN3: begin
        add_a = a_reg;
        add_b = b_reg;
      end
      DONE:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Operand latch, result capture and voting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg    <= '0;
      b_reg    <= '0;
      id_reg   <= 1'b0;
      r1_reg   <= '0;
      r2_reg   <= '0;
      sum_reg  <= '0;
      corr_reg <= 1'b0;
      err_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            a_reg  <= gnt[1] ? req1_a : req0_a;
            b_reg  <= gnt[1] ? req1_b : req0_b;
            id_reg <= gnt[1];
          end
        end
        RUN1: r1_reg <= add_o;
        RUN2: begin
          r2_reg <= add_o;
          if (add_o == r1_reg) begin
            sum_reg  <= r1_reg;
            corr_reg <= 1'b0;
            err_reg  <= 1'b0;
          end
        end
        RUN3: begin
          if ((add_o == r1_reg) || (add_o == r2_reg)) begin
            sum_reg  <= add_o;
            corr_reg <= 1'b1;
            err_reg  <= 1'b0;
          end else begin
            sum_reg  <= r1_reg;
            corr_reg <= 1'b0;
            err_reg  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Index 0 counts corrected responses, index 1 uncorrectable ones
  assign evt = {err_reg, corr_reg};

  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    logic [CNT_W-1:0] cnt_reg;

    // Saturating event counter, bumped on response handshake
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_reg <= '0;
      end else if (done_hs && evt[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end

    if (gi == 0) begin : g_corr
      assign corr_cnt = cnt_reg;
    end else begin : g_err
      assign err_cnt = cnt_reg;
    end
  end

endmodule

// File: tb/tb_addr8s_redundant_sched.sv
// Directed bench for addr8s_redundant_sched with a behavioural adder that can
// be overridden per evaluation cycle to inject faults.
module tb_addr8s_redundant_sched;

  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0_valid, req1_valid;
  logic [7:0]       req0_a, req0_b, req1_a, req1_b;
  logic             req0_ready, req1_ready;
  logic [7:0]       add_a, add_b;
  logic [8:0]       add_o;
  logic             rsp_valid, rsp_ready;
  logic             rsp_id;
  logic [8:0]       rsp_sum;
  logic             rsp_corrected, rsp_err;
  logic [CNT_W-1:0] corr_cnt, err_cnt;

  logic       ovr_en;
  logic [8:0] ovr_val;
  logic [8:0] ideal_sum;

  int checks = 0;
  int errors = 0;

  addr8s_redundant_sched #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .add_a(add_a), .add_b(add_b), .add_o(add_o),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum),
    .rsp_corrected(rsp_corrected), .rsp_err(rsp_err),
    .corr_cnt(corr_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // Ideal signed adder with optional fault override
  assign ideal_sum = {add_a[7], add_a} + {add_b[7], add_b};
  always_comb add_o = ovr_en ? ovr_val : ideal_sum;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b0;
    ovr_en = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic set_ovr(input int n, input logic [3:0] mask,
                         input logic [8:0] v1, input logic [8:0] v2, input logic [8:0] v3);
    ovr_en = 1'b0;
    case (n)
      1: begin ovr_en = mask[1]; ovr_val = v1; end
      2: begin ovr_en = mask[2]; ovr_val = v2; end
      3: begin ovr_en = mask[3]; ovr_val = v3; end
      default: ;
    endcase
  endtask

  // Accept edge is cycle 0; returns cycles until rsp_valid, -1 on timeout
  task automatic run_op(input logic [3:0] mask, input logic [8:0] v1,
                        input logic [8:0] v2, input logic [8:0] v3,
                        input bit keep, output int lat);
    int n;
    tick();
    n = 1;
    if (!keep) begin
      req0_valid = 1'b0;
      req1_valid = 1'b0;
    end
    set_ovr(n, mask, v1, v2, v3);
    #1;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
      set_ovr(n, mask, v1, v2, v3);
      #1;
    end
    ovr_en = 1'b0;
    lat = rsp_valid ? n : -1;
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b0;
    ovr_en = 1'b0;
    ovr_val = '0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    #2;
    rst = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    tick();
    checks++;
    if ({rsp_valid, rsp_id, rsp_sum, rsp_corrected, rsp_err} !== 13'd0) begin
      errors++;
      $display("FAIL reset_rsp: got valid=%b id=%b sum=%h c=%b e=%b, want all 0",
               rsp_valid, rsp_id, rsp_sum, rsp_corrected, rsp_err);
    end
    checks++;
    if ({req1_ready, req0_ready} !== 2'b00) begin
      errors++;
      $display("FAIL reset_ready: got %b%b want 00", req1_ready, req0_ready);
    end
    checks++;
    if ({add_a, add_b, corr_cnt, err_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_add_cnt: got a=%h b=%h corr=%0d err=%0d want 0",
               add_a, add_b, corr_cnt, err_cnt);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst = 1'b0;
    tick();
    $display("reset: done");
  endtask

  task automatic test_single();
    int lat;
    req0_a = 8'h7F; req0_b = 8'h01; req0_valid = 1'b1;
    #1;
    checks++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      errors++;
      $display("FAIL single_ready: got %b%b want 01", req1_ready, req0_ready);
    end
    run_op(4'b0000, 9'h0, 9'h0, 9'h0, 1'b0, lat);
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL single_latency: got %0d want 3", lat);
    end
    checks++;
    if ({rsp_id, rsp_sum, rsp_corrected, rsp_err} !== {1'b0, 9'h080, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL single_payload: got id=%b sum=%h c=%b e=%b want id=0 sum=080 c=0 e=0",
               rsp_id, rsp_sum, rsp_corrected, rsp_err);
    end
    checks++;
    if ({add_a, add_b} !== 16'h0) begin
      errors++;
      $display("FAIL single_add_done: got a=%h b=%h want 0", add_a, add_b);
    end
    handshake();
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_release: rsp_valid got %b want 0", rsp_valid);
    end
    $display("single: lat=%0d sum=%h", lat, rsp_sum);
  endtask

  task automatic test_contention();
    int lat;
    logic       exp_id;
    logic [8:0] exp_sum;
    apply_reset();
    req0_a = 8'h80; req0_b = 8'hFF;
    req1_a = 8'h10; req1_b = 8'h05;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_id  = i[0];
      exp_sum = exp_id ? 9'h015 : 9'h17F;
      #1;
      checks++;
      if ({req1_ready, req0_ready} !== (exp_id ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL contention_grant%0d: got %b%b want id %0d", i, req1_ready, req0_ready, exp_id);
      end
      run_op(4'b0000, 9'h0, 9'h0, 9'h0, 1'b1, lat);
      checks++;
      if ({lat == 3, rsp_id, rsp_sum} !== {1'b1, exp_id, exp_sum}) begin
        errors++;
        $display("FAIL contention_rsp%0d: got lat=%0d id=%b sum=%h want lat=3 id=%b sum=%h",
                 i, lat, rsp_id, rsp_sum, exp_id, exp_sum);
      end
      rsp_ready = 1'b1;
      #1;
      checks++;
      if ({req1_ready, req0_ready} !== 2'b00) begin
        errors++;
        $display("FAIL contention_no_accept%0d: got %b%b want 00", i, req1_ready, req0_ready);
      end
      tick();
      rsp_ready = 1'b0;
      $display("contention: op %0d id=%b sum=%h", i, rsp_id, rsp_sum);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
  endtask

  task automatic test_transient();
    int lat;
    req0_a = 8'h03; req0_b = 8'h04; req0_valid = 1'b1;
    #1;
    run_op(4'b0010, 9'h0AA, 9'h0, 9'h0, 1'b0, lat);
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL transient_latency: got %0d want 4", lat);
    end
    checks++;
    if ({rsp_sum, rsp_corrected, rsp_err} !== {9'h007, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL transient_payload: got sum=%h c=%b e=%b want sum=007 c=1 e=0",
               rsp_sum, rsp_corrected, rsp_err);
    end
    handshake();
    checks++;
    if ({corr_cnt, err_cnt} !== {2'd1, 2'd0}) begin
      errors++;
      $display("FAIL transient_cnt: got corr=%0d err=%0d want corr=1 err=0", corr_cnt, err_cnt);
    end
    $display("transient: lat=%0d sum=%h corr_cnt=%0d", lat, rsp_sum, corr_cnt);
  endtask

  task automatic test_triple();
    int lat;
    logic [CNT_W-1:0] exp_cnt;
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      req0_a = 8'h03; req0_b = 8'h04; req0_valid = 1'b1;
      #1;
      run_op(4'b1110, 9'h001, 9'h002, 9'h003, 1'b0, lat);
      checks++;
      if ({lat == 4, rsp_sum, rsp_corrected, rsp_err} !== {1'b1, 9'h001, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL triple_payload%0d: got lat=%0d sum=%h c=%b e=%b want lat=4 sum=001 c=0 e=1",
                 k, lat, rsp_sum, rsp_corrected, rsp_err);
      end
      handshake();
      exp_cnt = (k >= 2) ? 2'd3 : CNT_W'(k + 1);
      checks++;
      if (err_cnt !== exp_cnt) begin
        errors++;
        $display("FAIL triple_err_cnt%0d: got %0d want %0d", k, err_cnt, exp_cnt);
      end
      $display("triple: op %0d err_cnt=%0d", k, err_cnt);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    apply_reset();
    req1_a = 8'h55; req1_b = 8'h22; req1_valid = 1'b1;
    #1;
    run_op(4'b0000, 9'h0, 9'h0, 9'h0, 1'b0, lat);
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL bp_latency: got %0d want 3", lat);
    end
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if ({rsp_valid, rsp_id, rsp_sum, req1_ready, req0_ready} !== {1'b1, 1'b1, 9'h077, 2'b00}) begin
        errors++;
        $display("FAIL bp_hold%0d: got v=%b id=%b sum=%h rdy=%b%b want v=1 id=1 sum=077 rdy=00",
                 c, rsp_valid, rsp_id, rsp_sum, req1_ready, req0_ready);
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    handshake();
    $display("backpressure: held 10 cycles sum=%h", rsp_sum);
  endtask

  task automatic test_reset_run2();
    bit seen;
    apply_reset();
    req0_a = 8'h03; req0_b = 8'h04; req0_valid = 1'b1;
    tick();
    req0_valid = 1'b0;
    tick();
    checks++;
    if (add_a !== 8'h03) begin
      errors++;
      $display("FAIL abort_in_run2: add_a got %h want 03", add_a);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({rsp_valid, add_a, add_b, req1_ready, req0_ready} !== '0) begin
      errors++;
      $display("FAIL abort_idle: got v=%b a=%h b=%h rdy=%b%b want all 0",
               rsp_valid, add_a, add_b, req1_ready, req0_ready);
    end
    tick();
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (rsp_valid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_rsp: rsp_valid seen=%b want 0", seen);
    end
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    checks++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      errors++;
      $display("FAIL abort_prio: got %b%b want 01", req1_ready, req0_ready);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    $display("reset_run2: aborted op, priority back to req0");
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_transient();
    test_triple();
    test_backpressure();
    test_reset_run2();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/addr8s_redundant_sched.md
ADDR8S_REDUNDANT_SCHED -- requirements
Module: addr8s_redundant_sched

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of the saturating event counters.
REQ-002 SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports req0_valid/req1_valid  in  1  requester i has an operation pending.
REQ-005 SHALL have ports req0_a, req0_b, req1_a, req1_b  in  8  signed two's-complement operands.
REQ-006 SHALL have ports req0_ready/req1_ready  out  1  operation accepted this cycle when valid&ready.
REQ-007 SHALL have ports add_a, add_b  out  8  operands driven to the shared combinational 8-bit signed adder.
REQ-008 SHALL have port add_o  in  9  adder result, sampled the same cycle add_a/add_b are driven.
REQ-009 SHALL have ports rsp_valid in/out: rsp_valid out 1, rsp_ready in 1  response handshake.
REQ-010 SHALL have ports rsp_id out 1, rsp_sum out 9, rsp_corrected out 1, rsp_err out 1  response payload.
REQ-011 SHALL have ports corr_cnt, err_cnt  out  CNT_W  saturating counts of corrected and uncorrectable operations.

Function
REQ-012 SHALL implement FSM states IDLE, RUN1, RUN2, RUN3, DONE.
REQ-013 SHALL, in IDLE only, assert exactly one reqN_ready, chosen by round-robin among valid requesters; no ready when no valid.
REQ-014 SHALL, on accept, latch a, b and id, toggle round-robin priority to the other requester, and go to RUN1.
REQ-015 SHALL drive latched operands on add_a/add_b in RUN1, RUN2, RUN3; add_a/add_b SHALL be 0 in IDLE and DONE.
REQ-016 SHALL capture add_o as r1 in RUN1, r2 in RUN2, r3 in RUN3.
REQ-017 SHALL, in RUN2, go to DONE with rsp_sum=r1 if r1==r2, else go to RUN3.
REQ-018 SHALL, in RUN3, vote: r3==r1 or r3==r2 -> rsp_sum=r3, rsp_corrected=1; all differ -> rsp_sum=r1, rsp_err=1.
REQ-019 SHALL hold rsp_valid and payload stable in DONE until rsp_ready; on rsp_valid&rsp_ready return to IDLE.
REQ-020 SHALL give latency accept->rsp_valid of 3 cycles (agreement) or 4 cycles (RUN3 executed).
REQ-021 SHALL accept no new request in the cycle the response completes (IDLE re-entered first).
REQ-022 SHALL increment corr_cnt/err_cnt by 1 on handshake of a corrected/erroneous response, saturating at all-ones.
REQ-023 SHALL treat add_o as opaque 9-bit data: no sign extension or overflow checks in the scheduler.

Reset
REQ-024 SHALL, on rst, immediately go to IDLE, abandon any in-flight operation without response.
REQ-025 SHALL reset rsp_valid, rsp_id, rsp_sum, rsp_corrected, rsp_err, reqN_ready, add_a, add_b, corr_cnt, err_cnt to 0 and round-robin priority to requester 0.

Structure
REQ-026 SHALL place state enum, operand width (8) and result width (9) in shared package addr8s_pkg.
REQ-027 SHALL contain one sub-module rr_arb2 (two-requester round-robin arbiter with priority register); adder stays external.

Verification
REQ-028 Single op: req0 a=0x7F b=0x01, ideal adder -> rsp_valid 3 cycles after accept, rsp_sum=0x080, id=0, corrected=0, err=0.
REQ-029 Contention: both valid continuously after reset -> grants alternate 0,1,0,1; negative case a=0x80 b=0xFF -> rsp_sum=0x17F.
REQ-030 Transient fault: corrupt add_o in RUN1 only (a=3,b=4) -> latency 4, rsp_sum=0x007, corrected=1, corr_cnt=1.
REQ-031 Triple disagreement: add_o=1,2,3 in RUN1..RUN3 -> rsp_sum=0x001, err=1, err_cnt=1; with CNT_W=2 repeat 5x -> err_cnt=3.
REQ-032 Backpressure: rsp_ready low 10 cycles in DONE -> payload stable, both reqN_ready=0 throughout.
REQ-033 Reset in RUN2 -> next cycle IDLE, rsp_valid=0, priority to req0, no response for aborted op.
